uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver paired with the UART transmitter: recovers 7- or 8-bit frames with optional odd/even parity and one stop bit from `serial_in`, using a mid-bit sampling counter. Delivers the assembled word with a one-cycle `data_valid` strobe plus parity and framing error flags. Sits between the pad-side serial line and the host register interface. Its line settings use the same encoding as the transmit side.

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per bit period; even value, minimum 4.
- `clock`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial line; idle high.
- `data_length`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `parity_type`  in  2  01 = odd, 10 = even, 00/11 = no parity bit.
- `data_out`  out  8  received word, LSB first on the line; bit 7 = 0 in 7-bit mode.
- `data_valid`  out  1  one-cycle strobe: `data_out` and the error flags are updated.
- `parity_error`  out  1  parity mismatch for the frame reported by `data_valid`.
- `frame_error`  out  1  stop bit sampled low for that frame.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE:**
  - `serial_in` = 0 → START, bit counter cleared.
  - `data_length` and `parity_type` are latched on this transition and held for the whole frame.
- **START:**
  - After `CLKS_PER_BIT/2` cycles, sample the line.
  - 0 → DATA.
  - 1 → false start, return to IDLE with no strobe.
- **DATA:**
  - Sample every `CLKS_PER_BIT` cycles, shifting LSB first.
  - After 7 or 8 samples, go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY:**
  - Sample the parity bit after `CLKS_PER_BIT` cycles.
  - Odd: the count of ones in data plus parity must be odd.
  - Even: that count must be even.
  - A mismatch sets `parity_error` for this frame.
  - Only bits [MSB:0] count, where MSB = 7 or 6.
- **STOP:**
  - Sample after `CLKS_PER_BIT` cycles.
  - 1 → IDLE.
  - 0 → `frame_error`, then WAIT_HIGH.
  - Either way, on the next cycle pulse `data_valid`, load `data_out`, and load both flags.
- **WAIT_HIGH:** stay until `serial_in` = 1, then go to IDLE. A stuck-low or break line must not create spurious frames.
- **Held values:** `data_out`, `parity_error` and `frame_error` hold until the next `data_valid`.
- **Frame integrity:** changes to `data_length` or `parity_type` mid-frame have no effect on the current frame.
- **Reset:**
  - `rst` overrides everything, including mid-frame; the state goes to IDLE and the partial frame is dropped.
  - Reset values: `data_out` = 8'h00; `data_valid`, `parity_error`, `frame_error` and `rx_busy` = 0.

## Timing
- Let t0 be the first rising edge at which the FSM sees `serial_in` low in IDLE.
- Samples are taken at:
  - start bit: t0 + `CLKS_PER_BIT/2`;
  - data bit k (k from 0): t0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
- `data_valid` rises exactly 1 cycle after the stop-bit sample:
  - 8N1: t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1.
  - Add `CLKS_PER_BIT` for a parity bit; subtract `CLKS_PER_BIT` for 7-bit mode.
- Back-to-back frames: the FSM is in IDLE from mid stop bit onward, so a start edge immediately after the stop bit is accepted. There is no inter-frame gap requirement.
- Cycle counter width: `$clog2(CLKS_PER_BIT)`. It wraps to 0 on every sample.
- No backpressure: a frame not consumed before the next `data_valid` is overwritten.

## Configuration
- **`UART_RX_INSYNC_EN`**
  - Defined: `serial_in` passes through a 2-flop synchronizer (reset value 1) before the FSM. All sample times and t0 shift by +2 cycles relative to the pin.
  - Undefined: `serial_in` drives the FSM directly. The pin is then required to be synchronous to `clock`, which is the simulation-only configuration.

## Structure
- **Shared package `uart_pkg`:**
  - parity encodings `PARITY_NONE`, `PARITY_ODD` = 2'b01, `PARITY_EVEN` = 2'b10;
  - `DATA_LEN_7` / `DATA_LEN_8`;
  - the receiver state enum;
  - shared with the transmitter.
- **Sub-module `uart_rx_bitclk`:** the mid-bit cycle counter. It takes a load-half/load-full control and outputs a one-cycle `sample_tick`. The FSM, shift register and parity check stay in `uart_rx`.

## Test plan
Run with `CLKS_PER_BIT` = 16.
- **8N1, byte 8'hA5:** `data_valid` at t0 + 8 + 144 + 1; `data_out` = 8'hA5; both errors 0.
- **7-bit even, data 7'h55 (4 ones), parity bit 0:** `data_out` = 8'h55, `parity_error` = 0. Same frame with parity bit 1 → `parity_error` = 1.
- **8-bit odd, 8'hFF, parity bit 1:** no error. Resend with parity bit 0 → `parity_error` = 1.
- **Stop bit driven low, then line held low 40 bit-times:** one `data_valid` with `frame_error` = 1. No further strobes until the line returns high, then a new 8'h3C frame is received correctly.
- **Glitch:** line low for 5 cycles in IDLE → no strobe, back in IDLE, `rx_busy` drops by t0 + 9.
- **Reset mid-frame:** `rst` asserted during data bit 3 → all outputs 0 next cycle. A following frame of 8'h81 is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-setting encodings, receiver state enum and parity helpers.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  localparam logic DATA_LEN_7 = 1'b0;
  localparam logic DATA_LEN_8 = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
  endfunction

  // Unused high data bits must already be zero so they do not disturb the count.
  function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit,
                                           input logic [1:0] ptype);
    logic ones_odd;
    logic result;
    ones_odd = (^data) ^ pbit;
    case (ptype)
      PARITY_ODD:  result = ~ones_odd;
      PARITY_EVEN: result = ones_odd;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_bitclk.sv
// Mid-bit sampling counter: first tick half a bit after the load, then one tick per bit period.
module uart_rx_bitclk #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load_half,
  output logic o_sample_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_half;
  logic          w_at_last;

  assign w_at_last     = (r_cnt == (r_half ? HALF_LAST : FULL_LAST));
  assign o_sample_tick = w_at_last & ~i_load_half;

  // Cycle counter: held at zero in half mode while loading, wraps to zero on every sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_half <= 1'b1;
    end else if (i_load_half) begin
      r_cnt  <= '0;
      r_half <= 1'b1;
    end else if (w_at_last) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_half <= r_half;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 7/8 data bits, optional odd/even parity, one stop bit, mid-bit sampling.
// Define UART_RX_INSYNC_EN to put a 2-flop synchronizer on serial_in (adds 2 cycles of latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_busy
);

  logic w_rx;
  logic w_tick;
  logic w_load_half;

`ifdef UART_RX_INSYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer, reset to the idle-high line level.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], serial_in};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = serial_in;
`endif

  rx_state_t  r_state;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_len8;
  logic [1:0] r_ptype;
  logic       r_perr_pend;
  logic       r_ferr_pend;
  logic       r_pend;
  logic [2:0] w_last_idx;

  assign w_load_half = (r_state == RX_IDLE);
  assign w_last_idx  = r_len8 ? 3'd7 : 3'd6;
  assign rx_busy     = (r_state != RX_IDLE);

  uart_rx_bitclk #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitclk (
    .i_clk        (clock),
    .i_rst        (rst),
    .i_load_half  (w_load_half),
    .o_sample_tick(w_tick)
  );

  // Frame FSM; the result is published one cycle after the stop-bit sample via r_pend.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= RX_IDLE;
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'h00;
      r_len8       <= DATA_LEN_8;
      r_ptype      <= PARITY_NONE;
      r_perr_pend  <= 1'b0;
      r_ferr_pend  <= 1'b0;
      r_pend       <= 1'b0;
      data_out     <= 8'h00;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid <= r_pend;
      r_pend     <= 1'b0;
      if (r_pend) begin
        data_out     <= r_shift;
        parity_error <= r_perr_pend;
        frame_error  <= r_ferr_pend;
      end

      case (r_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_state     <= RX_START;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_perr_pend <= 1'b0;
            r_len8      <= (data_length == DATA_LEN_8);
            r_ptype     <= parity_type;
          end
        end
        RX_START: begin
          if (w_tick) begin
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_shift[r_bitcnt] <= w_rx;
            if (r_bitcnt == w_last_idx) begin
              r_state <= parity_enabled(r_ptype) ? RX_PARITY : RX_STOP;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            r_perr_pend <= parity_mismatch(r_shift, w_rx, r_ptype);
            r_state     <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            r_pend      <= 1'b1;
            r_ferr_pend <= ~w_rx;
            r_state     <= w_rx ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        // A break or stuck-low line parks here so it cannot start new frames.
        RX_WAIT_HIGH: begin
          if (w_rx) begin
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames, corner-case sequences, random frames.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_INSYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clock;
  logic       rst;
  logic       serial_in;
  logic       data_length;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic       l8;
    logic [1:0] pt;
    logic [7:0] d;
    logic       flip;
    logic [7:0] exp_d;
    logic       exp_pe;
    int         exp_lat;
  } vec_t;
  vec_t vt[8];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .rst         (rst),
    .serial_in   (serial_in),
    .data_length (data_length),
    .parity_type (parity_type),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .rx_busy     (rx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (data_valid) evq.push_back('{cyc, data_out, parity_error, frame_error});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at a negedge; line settings are scrambled after t0.
  task automatic send_frame(input logic l8, input logic [1:0] pt, input logic [7:0] d,
                            input logic pflip, input logic stopb, output int t0);
    int   nb;
    logic haspar;
    logic pbit;
    logic [7:0] dm;
    nb     = l8 ? 8 : 7;
    dm     = l8 ? d : (d & 8'h7F);
    haspar = (pt == 2'b01) || (pt == 2'b10);
    pbit   = ($countones(dm) % 2 == 1) ^ (pt == 2'b01) ^ pflip;
    data_length = l8;
    parity_type = pt;
    serial_in   = 1'b0;
    t0 = cyc + 1;
    repeat (2) @(negedge clock);
    data_length = 1'($urandom);
    parity_type = 2'($urandom);
    repeat (CPB - 2) @(negedge clock);
    for (int k = 0; k < nb; k++) begin
      serial_in = d[k];
      repeat (CPB) @(negedge clock);
    end
    if (haspar) begin
      serial_in = pbit;
      repeat (CPB) @(negedge clock);
    end
    serial_in = stopb;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] ed, input logic epe,
                              input logic efe, input int ecyc);
    int waited;
    ev_t e;
    waited = 0;
    while (evq.size() == 0 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (evq.size() == 0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      e = evq.pop_front();
      chk({name, "_data"}, 32'(e.d), 32'(ed));
      chk({name, "_perr"}, 32'(e.pe), 32'(epe));
      chk({name, "_ferr"}, 32'(e.fe), 32'(efe));
      chk({name, "_cycle"}, 32'(e.cyc), 32'(ecyc));
      chk({name, "_extra"}, 32'(evq.size()), 32'd0);
    end
  endtask

  initial begin
    int t0;
    logic       l8, fl, sb;
    logic [1:0] pt;
    logic [7:0] d, ed;
    int nb, hp, gap;

    vt[0] = '{1'b1, 2'b00, 8'hA5, 1'b0, 8'hA5, 1'b0, 153};
    vt[1] = '{1'b0, 2'b10, 8'h55, 1'b0, 8'h55, 1'b0, 153};
    vt[2] = '{1'b0, 2'b10, 8'h55, 1'b1, 8'h55, 1'b1, 153};
    vt[3] = '{1'b1, 2'b01, 8'hFF, 1'b0, 8'hFF, 1'b0, 169};
    vt[4] = '{1'b1, 2'b01, 8'hFF, 1'b1, 8'hFF, 1'b1, 169};
    vt[5] = '{1'b1, 2'b11, 8'h3C, 1'b0, 8'h3C, 1'b0, 153};
    vt[6] = '{1'b0, 2'b00, 8'hD3, 1'b0, 8'h53, 1'b0, 137};
    vt[7] = '{1'b0, 2'b01, 8'h00, 1'b1, 8'h00, 1'b1, 153};

    rst = 1'b1;
    serial_in = 1'b1;
    data_length = 1'b1;
    parity_type = 2'b00;
    repeat (4) @(negedge clock);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_perr", 32'(parity_error), 32'h0);
    chk("reset_ferr", 32'(frame_error), 32'h0);
    chk("reset_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clock);

    // Directed table, frames back to back.
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].l8, vt[i].pt, vt[i].d, vt[i].flip, 1'b1, t0);
      expect_frame($sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_pe, 1'b0,
                   t0 + SL + vt[i].exp_lat);
    end
    chk("held_data", 32'(data_out), 32'h00);
    chk("held_perr", 32'(parity_error), 32'h1);

    // Stop bit low, then a 40 bit-time break.
    send_frame(1'b1, 2'b00, 8'h12, 1'b0, 1'b0, t0);
    expect_frame("brk", 8'h12, 1'b0, 1'b1, t0 + SL + 153);
    repeat (40 * CPB) @(negedge clock);
    chk("brk_no_strobe", 32'(evq.size()), 32'd0);
    chk("brk_busy", 32'(rx_busy), 32'd1);
    chk("brk_ferr_held", 32'(frame_error), 32'd1);
    serial_in = 1'b1;
    repeat (4) @(negedge clock);
    chk("brk_idle", 32'(rx_busy), 32'd0);
    send_frame(1'b1, 2'b00, 8'h3C, 1'b0, 1'b1, t0);
    expect_frame("after_brk", 8'h3C, 1'b0, 1'b0, t0 + SL + 153);
    repeat (10) @(negedge clock);

    // Five-cycle glitch in IDLE.
    serial_in = 1'b0;
    t0 = cyc + 1;
    repeat (3) @(negedge clock);
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    repeat (2) @(negedge clock);
    serial_in = 1'b1;
    while (cyc < t0 + 9 + SL) @(negedge clock);
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    repeat (3 * CPB) @(negedge clock);
    chk("glitch_no_strobe", 32'(evq.size()), 32'd0);

    // Reset in the middle of data bit 3 of 8'h81.
    d = 8'h81;
    data_length = 1'b1;
    parity_type = 2'b00;
    serial_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      serial_in = d[k];
      repeat (CPB) @(negedge clock);
    end
    serial_in = d[3];
    repeat (CPB / 2) @(negedge clock);
    chk("midrst_busy_before", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clock);
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_valid", 32'(data_valid), 32'h0);
    chk("midrst_perr", 32'(parity_error), 32'h0);
    chk("midrst_ferr", 32'(frame_error), 32'h0);
    chk("midrst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    serial_in = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    chk("midrst_no_strobe", 32'(evq.size()), 32'd0);
    send_frame(1'b1, 2'b00, 8'h81, 1'b0, 1'b1, t0);
    expect_frame("after_rst", 8'h81, 1'b0, 1'b0, t0 + SL + 153);

    // Random frames against the reference model.
    for (int i = 0; i < 25; i++) begin
      l8 = 1'($urandom);
      pt = 2'($urandom);
      d  = 8'($urandom);
      fl = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(l8, pt, d, fl, sb, t0);
      nb = l8 ? 8 : 7;
      hp = ((pt == 2'b01) || (pt == 2'b10)) ? 1 : 0;
      ed = l8 ? d : {1'b0, d[6:0]};
      expect_frame($sformatf("rnd%0d", i), ed, (hp == 1) && fl, ~sb,
                   t0 + SL + CPB / 2 + CPB * (nb + hp + 1) + 1);
      serial_in = 1'b1;
      gap = sb ? $urandom_range(0, 3) : $urandom_range(1, 3);
      repeat (gap) @(negedge clock);
    end

    repeat (3 * CPB) @(negedge clock);
    chk("final_no_strobe", 32'(evq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
